// File: rtl/conv_encoder_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_encoder_packer_if : byte input / coded-word output stream bundle      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface conv_encoder_packer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/conv_encoder_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_encoder_packer : rate-1/2 K=3 encoder, one 16-bit word per byte, FIFO |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module conv_encoder_packer #(
  parameter int         DEPTH = 2,
  parameter logic [2:0] G0    = 3'b111,
  parameter logic [2:0] G1    = 3'b101
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  conv_encoder_packer_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]      fifo_count,
  output logic                            busy
);
  localparam int                PTR_W     = $clog2(DEPTH);
  localparam int                CNT_W     = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    PUSH   = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [7:0]        data_byte;
  logic [15:0]       word;
  logic              s1, s0;
  logic [2:0]        bit_cnt;
  logic [15:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              u;
  logic [2:0]        taps;
  logic [1:0]        sym;
  logic              ready;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_ok;

  assign u    = data_byte[bit_cnt];
  assign taps = {u, s1, s0};
  assign sym  = {^(G0 & taps), ^(G1 & taps)};

  assign pop     = (count != '0) && bus.out_ready;
  // A full FIFO still takes the word if the head leaves on the same edge.
  assign fifo_ok = (count < DEPTH_CNT) || pop;

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = ENCODE;
        end
      end
      ENCODE: begin
        if (bit_cnt == 3'd7) state_next = PUSH;
      end
      PUSH: begin
        if (fifo_ok) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_byte <= 8'h00;
      word      <= 16'h0000;
      s1        <= 1'b0;
      s0        <= 1'b0;
      bit_cnt   <= 3'd0;
    end else begin
      if (accept) begin
        data_byte <= bus.in_data;
        s1        <= 1'b0;
        s0        <= 1'b0;
        bit_cnt   <= 3'd0;
      end
      if (state == ENCODE) begin
        word[{bit_cnt, 1'b0} +: 2] <= sym;
        s0      <= s1;
        s1      <= u;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = (count != '0) ? mem[rd_ptr] : 16'h0000;
  assign fifo_count    = count;
  assign busy          = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv_encoder_packer : directed + random bench with byte->word scoreboard|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_conv_encoder_packer;
  localparam int LIMIT = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fifo_count;
  logic       busy;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expq[$];

  always #5 clk = ~clk;

  conv_encoder_packer_if bus ();

  conv_encoder_packer #(.DEPTH(2), .G0(3'b111), .G1(3'b101)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbol pair i depends on data bit i and the two bits sent before it in the same byte.
  function automatic logic [15:0] ref_encode(input logic [7:0] b);
    logic [15:0] w;
    logic        cur, prev1, prev2;
    w = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      cur   = b[i];
      prev1 = (i >= 1) ? b[i-1] : 1'b0;
      prev2 = (i >= 2) ? b[i-2] : 1'b0;
      w[2*i+1] = cur ^ prev1 ^ prev2;
      w[2*i]   = cur ^ prev2;
    end
    return w;
  endfunction

  task automatic tick();
    logic fin, fout;
    fin  = bus.in_valid && bus.in_ready && !rst;
    fout = bus.out_valid && bus.out_ready && !rst;
    if (!bus.out_valid) check("idle_data_zero", bus.out_data, 16'h0000);
    check("ready_vs_busy", bus.in_ready, !busy);
    check("count_bound", (fifo_count <= 2'd2), 1'b1);
    if (fout) begin
      check("pop_nonempty", (expq.size() != 0), 1'b1);
      if (expq.size() != 0) check("pop_data", bus.out_data, expq.pop_front());
    end
    if (fin) expq.push_back(ref_encode(bus.in_data));
    @(posedge clk);
    #1;
    if (rst) expq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < LIMIT) begin
      tick();
      n++;
    end
    check("accept_timeout", (n < LIMIT), 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < LIMIT) begin
      tick();
      n++;
    end
    check("valid_timeout", (n < LIMIT), 1'b1);
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset in the middle of an encode
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("mid_encode_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_count", fifo_count, 2'd0);
    check("rst_out_data", bus.out_data, 16'h0000);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    check("rst_discards_word", bus.out_valid, 1'b0);

    // latency of a single byte
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h01;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("lat_not_early", bus.out_valid, 1'b0);
    end
    tick();
    check("lat_valid_e9", bus.out_valid, 1'b1);
    check("lat_data_01", bus.out_data, 16'h003B);
    check("lat_count", fifo_count, 2'd1);
    tick();
    check("popped_valid", bus.out_valid, 1'b0);
    check("popped_data", bus.out_data, 16'h0000);

    // no state carry-over between bytes
    send_byte(8'hFF);
    wait_valid();
    check("data_ff", bus.out_data, 16'hAAA7);
    tick();
    send_byte(8'h01);
    wait_valid();
    check("data_01_after_ff", bus.out_data, 16'h003B);
    tick();

    // full FIFO, third word stalls, then push+pop on one edge
    bus.out_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h01);
    for (int i = 0; i < 12; i++) tick();
    check("full_count", fifo_count, 2'd2);
    check("stall_busy", busy, 1'b1);
    check("stall_in_ready", bus.in_ready, 1'b0);
    check("stall_head", bus.out_data, 16'h003B);
    bus.out_ready = 1'b1;
    tick();
    check("simul_count", fifo_count, 2'd2);
    check("simul_busy", busy, 1'b0);
    check("simul_head", bus.out_data, 16'hAAA7);
    n = 0;
    while (bus.out_valid && n < LIMIT) begin
      tick();
      n++;
    end
    check("drain_timeout", (n < LIMIT), 1'b1);
    check("drain_empty", expq.size(), 0);

    // all-zero byte is still queued
    bus.out_ready = 1'b0;
    send_byte(8'h00);
    wait_valid();
    check("zero_valid", bus.out_valid, 1'b1);
    check("zero_data", bus.out_data, 16'h0000);
    check("zero_count", fifo_count, 2'd1);
    bus.out_ready = 1'b1;
    tick();

    // pointer wrap with random back-pressure
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = 1'($urandom);
      send_byte(8'($urandom));
    end

    // fully random traffic
    for (int i = 0; i < 800; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((busy || bus.out_valid) && n < LIMIT) begin
      tick();
      n++;
    end
    check("final_drain_timeout", (n < LIMIT), 1'b1);
    check("final_queue_empty", expq.size(), 0);
    check("final_count", fifo_count, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
